// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : SPI mode-0 initiator. Byte-stream handshake on the fabric
//                side, MSB-first shifting, rising-edge sampling, active-low
//                chip select with programmable setup, hold and idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       txValid,
  input  logic [7:0] txData,
  input  logic       txLast,
  output logic       txReady,
  output logic       rxValid,
  output logic [7:0] rxData,
  output logic       busy,
  output logic       oSPIClk,
  output logic       oSPIMOSI,
  input  logic       iSPIMISO,
  output logic       oSPICS
);

  localparam logic [7:0] c_clk_div  = 8'(CLK_DIV);
  localparam logic [7:0] c_cs_setup = 8'(CS_SETUP);
  localparam logic [7:0] c_cs_hold  = 8'(CS_HOLD);
  localparam logic [7:0] c_cs_idle  = 8'(CS_IDLE);

  // LOAD is the one-cycle slot between an accept and the first visible
  // effect on the bus, so MOSI/CS change one edge after the handshake.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_LOW   = 3'd3,
    S_HIGH  = 3'd4,
    S_WAIT  = 3'd5,
    S_HOLD  = 3'd6,
    S_GAP   = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] txsh_q, txsh_d;
  logic       last_q, last_d;
  logic [7:0] rxsh_q, rxsh_d;
  logic       cs_q, cs_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       rxvalid_q, rxvalid_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       busy_q, busy_d;
  logic       txready_q, txready_d;
  logic       accept;

  assign accept   = txValid && txready_q;
  assign txReady  = txready_q;
  assign rxValid  = rxvalid_q;
  assign rxData   = rxdata_q;
  assign busy     = busy_q;
  assign oSPIClk  = sclk_q;
  assign oSPIMOSI = mosi_q;
  assign oSPICS   = cs_q;

  // Next-state and registered-output logic; every counter reloads on state entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    txsh_d    = txsh_q;
    last_d    = last_q;
    rxsh_d    = rxsh_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    rxvalid_d = 1'b0;
    rxdata_d  = rxdata_q;
    busy_d    = busy_q;
    txready_d = txready_q;
    case (state_q)
      S_IDLE: begin
        txready_d = 1'b1;
        busy_d    = 1'b0;
        if (accept) begin
          txsh_d    = txData;
          last_d    = txLast;
          txready_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        mosi_d = txsh_q[7];
        bit_d  = 4'd0;
        if (cs_q) begin
          // First byte of a transaction: assert CS and run the setup time.
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
          cnt_d   = c_cs_setup;
        end else begin
          state_d = S_LOW;
          cnt_d   = c_clk_div;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd1) begin
          state_d = S_LOW;
          cnt_d   = c_clk_div;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LOW: begin
        if (cnt_q == 8'd1) begin
          state_d = S_HIGH;
          cnt_d   = c_clk_div;
          sclk_d  = 1'b1;
          rxsh_d  = {rxsh_q[6:0], iSPIMISO};
          bit_d   = bit_q + 4'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == 8'd1) begin
          sclk_d = 1'b0;
          if (bit_q == 4'd8) begin
            rxdata_d  = rxsh_q;
            rxvalid_d = 1'b1;
            if (last_q) begin
              state_d = S_HOLD;
              cnt_d   = c_cs_hold;
            end else begin
              state_d   = S_WAIT;
              txready_d = 1'b1;
            end
          end else begin
            mosi_d  = txsh_q[6];
            txsh_d  = {txsh_q[6:0], 1'b0};
            state_d = S_LOW;
            cnt_d   = c_clk_div;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_WAIT: begin
        if (accept) begin
          txsh_d    = txData;
          last_d    = txLast;
          txready_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd1) begin
          cs_d    = 1'b1;
          state_d = S_GAP;
          cnt_d   = c_cs_idle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd1) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          txready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous abort to the idle values.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 4'd0;
      txsh_q    <= 8'd0;
      last_q    <= 1'b0;
      rxsh_q    <= 8'd0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      rxvalid_q <= 1'b0;
      rxdata_q  <= 8'd0;
      busy_q    <= 1'b0;
      txready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      txsh_q    <= txsh_d;
      last_q    <= last_d;
      rxsh_q    <= rxsh_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      rxvalid_q <= rxvalid_d;
      rxdata_q  <= rxdata_d;
      busy_q    <= busy_d;
      txready_q <= txready_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Scoreboard bench for spi_master: a mode-0 slave model on one
//                instance (CLK_DIV=2) and a MOSI->MISO loopback on a second
//                instance (CLK_DIV=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // instance A: slave model
  logic       a_txValid = 1'b0;
  logic [7:0] a_txData  = 8'h00;
  logic       a_txLast  = 1'b0;
  logic       a_miso    = 1'b0;
  logic       a_txReady, a_rxValid, a_busy, a_sclk, a_mosi, a_cs;
  logic [7:0] a_rxData;

  spi_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(3)) u_dut_a (
    .sysclk(clk), .reset(rst),
    .txValid(a_txValid), .txData(a_txData), .txLast(a_txLast), .txReady(a_txReady),
    .rxValid(a_rxValid), .rxData(a_rxData), .busy(a_busy),
    .oSPIClk(a_sclk), .oSPIMOSI(a_mosi), .iSPIMISO(a_miso), .oSPICS(a_cs)
  );

  // instance B: loopback
  logic       b_txValid = 1'b0;
  logic [7:0] b_txData  = 8'h00;
  logic       b_txLast  = 1'b0;
  logic       b_txReady, b_rxValid, b_busy, b_sclk, b_mosi, b_cs;
  logic [7:0] b_rxData;

  spi_master #(.CLK_DIV(1)) u_dut_b (
    .sysclk(clk), .reset(rst),
    .txValid(b_txValid), .txData(b_txData), .txLast(b_txLast), .txReady(b_txReady),
    .rxValid(b_rxValid), .rxData(b_rxData), .busy(b_busy),
    .oSPIClk(b_sclk), .oSPIMOSI(b_mosi), .iSPIMISO(b_mosi), .oSPICS(b_cs)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  logic [7:0] exp_rx_a[$];
  logic [7:0] exp_mosi_a[$];
  logic [7:0] slv_q[$];
  logic [7:0] exp_rx_b[$];

  // slave model state and bus event bookkeeping
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  int  slv_bits   = 0;
  int  a_rises    = 0;
  int  a_cs_rises = 0;
  int  rx_cnt_a   = 0;
  int  b_rises    = 0;
  time a_first_rise = 0, a_last_fall = 0, a_cs_fall = 0, a_cs_rise = 0;
  time b_rise1 = 0, b_rise2 = 0;

  always @(negedge a_cs) begin
    a_cs_fall = $time;
    slv_bits  = 0;
    slv_tx    = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
    a_miso    = slv_tx[7];
  end

  always @(posedge a_cs) begin
    a_cs_rise = $time;
    a_cs_rises++;
  end

  always @(posedge a_sclk) begin
    logic [7:0] e;
    a_rises++;
    if (a_rises == 1) a_first_rise = $time;
    slv_rx = {slv_rx[6:0], a_mosi};
    slv_bits++;
    if (slv_bits == 8) begin
      if (exp_mosi_a.size() == 0) chk(1'b0, "mosi_unexpected", slv_rx, 0);
      else begin
        e = exp_mosi_a.pop_front();
        chk(slv_rx == e, "mosi_byte", slv_rx, e);
      end
    end
  end

  always @(negedge a_sclk) begin
    a_last_fall = $time;
    if (slv_bits >= 8) begin
      slv_bits = 0;
      slv_tx   = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
    end else begin
      slv_tx = {slv_tx[6:0], 1'b0};
    end
    a_miso = slv_tx[7];
  end

  always @(posedge b_sclk) begin
    b_rises++;
    if (b_rises == 1) b_rise1 = $time;
    if (b_rises == 2) b_rise2 = $time;
  end

  // received-byte monitor: pops the scoreboard whenever rxValid is seen
  always @(negedge clk) begin
    logic [7:0] e;
    if (a_rxValid) begin
      rx_cnt_a++;
      if (exp_rx_a.size() == 0) chk(1'b0, "rx_a_unexpected", a_rxData, 0);
      else begin
        e = exp_rx_a.pop_front();
        chk(a_rxData == e, "rx_a_byte", a_rxData, e);
      end
    end
    if (b_rxValid) begin
      if (exp_rx_b.size() == 0) chk(1'b0, "rx_b_unexpected", b_rxData, 0);
      else begin
        e = exp_rx_b.pop_front();
        chk(b_rxData == e, "rx_b_byte", b_rxData, e);
      end
    end
  end

  task automatic send_a(input logic [7:0] d, input logic l, input logic [7:0] rsp, output time acc);
    int n = 0;
    @(negedge clk);
    a_txValid = 1'b1; a_txData = d; a_txLast = l;
    while (a_txReady !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk(1'b0, "accept_timeout", n, 500);
    exp_mosi_a.push_back(d);
    exp_rx_a.push_back(rsp);
    @(posedge clk);
    acc = $time;
    #1;
    a_txValid = 1'b0; a_txData = 8'h00; a_txLast = 1'b0;
  endtask

  task automatic wait_cs_high_a();
    int n = 0;
    while (a_cs !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    while (a_cs !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk(1'b0, "cs_timeout", n, 1000);
  endtask

  // waits for CS to rise, then checks hold time and the idle gap
  task automatic wait_done_a();
    int  g = 0;
    bit  busy_ok = 1'b1;
    wait_cs_high_a();
    chk((a_cs_rise - a_last_fall) / 10 == 2, "cs_hold", (a_cs_rise - a_last_fall) / 10, 2);
    while (a_txReady == 1'b0 && g < 20) begin
      if (a_busy !== 1'b1) busy_ok = 1'b0;
      g++;
      @(negedge clk);
    end
    chk(g == 3, "gap_cycles", g, 3);
    chk(busy_ok, "gap_busy", busy_ok, 1);
    chk(a_busy == 1'b0, "busy_idle", a_busy, 0);
  endtask

  initial begin
    time acc, acc2;
    int  n, cs_r0;
    bit  stall_ok;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk(a_cs == 1'b1,       "rst_cs",      a_cs, 1);
    chk(a_sclk == 1'b0,     "rst_sclk",    a_sclk, 0);
    chk(a_mosi == 1'b0,     "rst_mosi",    a_mosi, 0);
    chk(a_rxValid == 1'b0,  "rst_rxvalid", a_rxValid, 0);
    chk(a_rxData == 8'h00,  "rst_rxdata",  a_rxData, 0);
    chk(a_busy == 1'b0,     "rst_busy",    a_busy, 0);
    chk(a_txReady == 1'b0,  "rst_txready", a_txReady, 0);
    rst = 1'b0;
    a_cs_rises = 0;
    a_rises    = 0;
    b_rises    = 0;
    @(negedge clk);
    chk(a_txReady == 1'b1, "txready_after_reset", a_txReady, 1);

    // single byte A5 / slave 3C
    slv_q.push_back(8'h3C);
    a_rises = 0; rx_cnt_a = 0;
    send_a(8'hA5, 1'b1, 8'h3C, acc);
    wait_done_a();
    chk(a_rises == 8, "single_rises", a_rises, 8);
    chk((a_first_rise - acc) / 10 == 5, "first_rise_delay", (a_first_rise - acc) / 10, 5);
    chk((a_cs_fall - acc) / 10 == 1, "cs_fall_delay", (a_cs_fall - acc) / 10, 1);
    chk(rx_cnt_a == 1, "single_rx_pulses", rx_cnt_a, 1);

    // three-byte burst
    slv_q.push_back(8'hFE); slv_q.push_back(8'h7F); slv_q.push_back(8'h00);
    a_rises = 0; rx_cnt_a = 0; cs_r0 = a_cs_rises;
    send_a(8'h01, 1'b0, 8'hFE, acc);
    send_a(8'h80, 1'b0, 8'h7F, acc);
    send_a(8'hFF, 1'b1, 8'h00, acc);
    wait_done_a();
    chk(a_rises == 24, "burst_rises", a_rises, 24);
    chk(a_cs_rises - cs_r0 == 1, "burst_cs_rises", a_cs_rises - cs_r0, 1);
    chk(rx_cnt_a == 3, "burst_rx_pulses", rx_cnt_a, 3);

    // source stall in WAIT
    slv_q.push_back(8'h34); slv_q.push_back(8'hAA);
    send_a(8'h12, 1'b0, 8'h34, acc);
    n = 0;
    while (a_txReady !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk(n < 200, "wait_entry", n, 0);
    stall_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (a_sclk !== 1'b0 || a_cs !== 1'b0 || a_txReady !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
    chk(stall_ok, "stall_bus_quiet", stall_ok, 1);
    send_a(8'h55, 1'b1, 8'hAA, acc);
    wait_done_a();

    // reset mid-byte
    slv_q.push_back(8'h0F);
    a_rises = 0;
    send_a(8'hF0, 1'b1, 8'h0F, acc);
    n = 0;
    while (a_rises < 4 && n < 200) begin @(negedge clk); n++; end
    chk(a_rises == 4, "abort_rises", a_rises, 4);
    rst = 1'b1;
    #1;
    chk(a_cs == 1'b1, "abort_cs", a_cs, 1);
    chk(a_sclk == 1'b0, "abort_sclk", a_sclk, 0);
    chk(a_rxValid == 1'b0, "abort_rxvalid", a_rxValid, 0);
    exp_mosi_a.delete(); exp_rx_a.delete(); slv_q.delete();
    @(negedge clk);
    rst = 1'b0;
    slv_q.push_back(8'h5A);
    send_a(8'hC3, 1'b1, 8'h5A, acc);
    wait_done_a();

    // back-to-back transactions: next accept not before CS high + CS_IDLE
    slv_q.push_back(8'h66);
    send_a(8'h11, 1'b1, 8'h66, acc);
    wait_cs_high_a();
    slv_q.push_back(8'h99);
    send_a(8'h22, 1'b1, 8'h99, acc2);
    chk((acc2 - a_cs_rise) / 10 >= 3, "b2b_accept_gap", (acc2 - a_cs_rise) / 10, 3);
    wait_done_a();

    // CLK_DIV=1 loopback
    b_rises = 0;
    @(negedge clk);
    b_txValid = 1'b1; b_txData = 8'h96; b_txLast = 1'b1;
    n = 0;
    while (b_txReady !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    exp_rx_b.push_back(8'h96);
    @(posedge clk);
    #1;
    b_txValid = 1'b0; b_txData = 8'h00; b_txLast = 1'b0;
    n = 0;
    while (b_cs !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    while (b_cs !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk(n < 200, "b_done", n, 0);
    chk(b_rises == 8, "b_rises", b_rises, 8);
    chk((b_rise2 - b_rise1) / 10 == 2, "b_sclk_period", (b_rise2 - b_rise1) / 10, 2);

    repeat (5) @(negedge clk);
    chk(exp_rx_a.size() == 0, "rx_a_left", exp_rx_a.size(), 0);
    chk(exp_mosi_a.size() == 0, "mosi_left", exp_mosi_a.size(), 0);
    chk(exp_rx_b.size() == 0, "rx_b_left", exp_rx_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
